// File: rtl/spi_frame_fifo_packer_if.sv
// Bundle of sample-input, frame-request and status signals between the
// coordinate source / SPI slave (master side) and the frame packer (slave side).
interface spi_frame_fifo_packer_if #(
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int ETC_W = 5,
  parameter int SEQ_W = 4,
  parameter int CHK_W = 4,
  parameter int DEPTH = 4
);
  localparam int FRAME_W = X_W + Y_W + ETC_W + SEQ_W + CHK_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               sample_valid;
  logic [X_W-1:0]     xdata;
  logic [Y_W-1:0]     ydata;
  logic [ETC_W-1:0]   etc;
  logic               frame_req;
  logic               clear_ovf;
  logic [FRAME_W-1:0] data_frame;
  logic               frame_fresh;
  logic [CNT_W-1:0]   fifo_count;
  logic               overflow;
  logic [7:0]         drop_cnt;

  modport master (
    output sample_valid, xdata, ydata, etc, frame_req, clear_ovf,
    input  data_frame, frame_fresh, fifo_count, overflow, drop_cnt
  );

  modport slave (
    input  sample_valid, xdata, ydata, etc, frame_req, clear_ovf,
    output data_frame, frame_fresh, fifo_count, overflow, drop_cnt
  );
endinterface

// File: rtl/spi_frame_fifo_packer.sv
// Packs coordinate samples with sequence number and XOR checksum into a small
// circular FIFO; the SPI slave pops one frame per frame_req, oldest dropped on overflow.
module spi_frame_fifo_packer #(
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int ETC_W = 5,
  parameter int SEQ_W = 4,
  parameter int CHK_W = 4,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  spi_frame_fifo_packer_if.slave bus
);
  localparam int P_W     = X_W + Y_W + ETC_W + SEQ_W;
  localparam int FRAME_W = P_W + CHK_W;
  localparam int NSL     = (P_W + CHK_W - 1) / CHK_W;
  localparam int PAD_W   = NSL * CHK_W;
  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_W   = AW + 1;

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               fresh_q, fresh_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         drop_q, drop_d;

  logic [P_W-1:0]     payload;
  logic [PAD_W-1:0]   pad;
  logic [CHK_W-1:0]   chk;
  logic               full, empty, pop, drop;

  always_comb begin
    payload = {bus.xdata, bus.ydata, bus.etc, seq_q};
    pad     = PAD_W'(payload);
    chk     = '0;
    for (int i = 0; i < NSL; i++) chk = chk ^ pad[i*CHK_W +: CHK_W];
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = bus.frame_req && !empty;
  // A pop in the same cycle makes room, so only an unserviced push at full drops.
  assign drop  = bus.sample_valid && !bus.frame_req && full;

  always_comb begin
    wr_ptr_d = bus.sample_valid ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = (pop || drop) ? rd_ptr_q + AW'(1) : rd_ptr_q;
    seq_d    = bus.sample_valid ? seq_q + SEQ_W'(1) : seq_q;
    count_d  = count_q;
    if (bus.sample_valid && !pop && !drop) count_d = count_q + CNT_W'(1);
    else if (pop && !bus.sample_valid)     count_d = count_q - CNT_W'(1);
    frame_d = pop ? mem_q[rd_ptr_q] : frame_q;
    fresh_d = bus.frame_req ? pop : fresh_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = bus.clear_ovf ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
    end else if (bus.clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      frame_q  <= '0;
      fresh_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      frame_q  <= frame_d;
      fresh_q  <= fresh_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the pointers and count alone define valid contents.
  always_ff @(posedge clk) begin
    if (bus.sample_valid) mem_q[wr_ptr_q] <= {payload, chk};
  end

  assign bus.data_frame  = frame_q;
  assign bus.frame_fresh = fresh_q;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.drop_cnt    = drop_q;
endmodule

// File: tb/tb_spi_frame_fifo_packer.sv
// Scoreboard bench for spi_frame_fifo_packer at default parameters.
module tb_spi_frame_fifo_packer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_frame_fifo_packer_if bus ();
  spi_frame_fifo_packer dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [31:0] sb [$];
  logic [3:0]  m_seq;
  logic        m_ovf;
  logic [7:0]  m_drop;
  logic [31:0] m_frame;
  logic        m_fresh;

  function automatic logic [31:0] mk_frame(logic [9:0] x, logic [8:0] y, logic [4:0] e, logic [3:0] s);
    logic [27:0] p;
    logic [3:0]  c;
    p = {x, y, e, s};
    c = 4'h0;
    for (int i = 0; i < 7; i++) c = c ^ 4'((p >> (4*i)) & 28'hF);
    return {p, c};
  endfunction

  task automatic step(input logic sv, input logic [9:0] x, input logic [8:0] y,
                      input logic [4:0] e, input logic fr, input logic clr);
    bus.sample_valid = sv; bus.xdata = x; bus.ydata = y; bus.etc = e;
    bus.frame_req = fr; bus.clear_ovf = clr;
    @(posedge clk);
    if (fr && sb.size() > 0) begin
      m_frame = sb.pop_front();
      m_fresh = 1'b1;
    end else if (fr) begin
      m_fresh = 1'b0;
    end
    if (sv) begin
      if (!fr && sb.size() == 4) begin
        void'(sb.pop_front());
        m_ovf  = 1'b1;
        m_drop = clr ? 8'd1 : ((m_drop == 8'hFF) ? m_drop : m_drop + 8'd1);
      end else if (clr) begin
        m_ovf = 1'b0; m_drop = 8'd0;
      end
      sb.push_back(mk_frame(x, y, e, m_seq));
      m_seq = m_seq + 4'd1;
    end else if (clr) begin
      m_ovf = 1'b0; m_drop = 8'd0;
    end
    #1;
    bus.sample_valid = 1'b0; bus.frame_req = 1'b0; bus.clear_ovf = 1'b0;
  endtask

  task automatic push_rand(input logic fr);
    step(1'b1, 10'($urandom_range(0, 1023)), 9'($urandom_range(0, 511)),
         5'($urandom_range(0, 31)), fr, 1'b0);
  endtask

  task automatic req();
    step(1'b0, 10'd0, 9'd0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    #2;
    sb.delete();
    m_seq = 4'd0; m_ovf = 1'b0; m_drop = 8'd0; m_frame = 32'd0; m_fresh = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    assert_reset();
    tests++; if (bus.data_frame !== 32'd0) begin fails++; $display("FAIL reset_frame got %h want 0", bus.data_frame); end
    tests++; if (bus.frame_fresh !== 1'b0) begin fails++; $display("FAIL reset_fresh got %b want 0", bus.frame_fresh); end
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
    tests++; if (bus.drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_drop got %0d want 0", bus.drop_cnt); end
    release_reset();
  endtask

  task automatic test_single();
    step(1'b1, 10'h155, 9'h0AA, 5'h13, 1'b0, 1'b0);
    tests++; if (bus.fifo_count !== 3'd1) begin fails++; $display("FAIL single_count1 got %0d want 1", bus.fifo_count); end
    tests++; if (bus.data_frame !== 32'd0) begin fails++; $display("FAIL single_hold got %h want 0", bus.data_frame); end
    req();
    tests++; if (bus.data_frame !== 32'h55555306) begin fails++; $display("FAIL single_frame got %h want 55555306", bus.data_frame); end
    tests++; if (bus.data_frame !== m_frame) begin fails++; $display("FAIL single_sb got %h want %h", bus.data_frame, m_frame); end
    tests++; if (bus.frame_fresh !== 1'b1) begin fails++; $display("FAIL single_fresh got %b want 1", bus.frame_fresh); end
    tests++; if (bus.fifo_count !== 3'd0) begin fails++; $display("FAIL single_count0 got %0d want 0", bus.fifo_count); end
    step(1'b0, 10'd0, 9'd0, 5'd0, 1'b0, 1'b0);
    tests++; if (bus.frame_fresh !== 1'b1) begin fails++; $display("FAIL fresh_hold got %b want 1", bus.frame_fresh); end
  endtask

  task automatic test_empty_req();
    req();
    tests++; if (bus.data_frame !== 32'h55555306) begin fails++; $display("FAIL empty_frame got %h want 55555306", bus.data_frame); end
    tests++; if (bus.frame_fresh !== 1'b0) begin fails++; $display("FAIL empty_fresh got %b want 0", bus.frame_fresh); end
  endtask

  task automatic test_overflow();
    assert_reset();
    release_reset();
    for (int i = 0; i < 6; i++) push_rand(1'b0);
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    tests++; if (bus.drop_cnt !== 8'd2) begin fails++; $display("FAIL ovf_drop got %0d want 2", bus.drop_cnt); end
    tests++; if (bus.fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d want 4", bus.fifo_count); end
    for (int i = 0; i < 4; i++) begin
      req();
      tests++; if (bus.data_frame[7:4] !== 4'(i + 2)) begin fails++; $display("FAIL ovf_seq%0d got %0d want %0d", i, bus.data_frame[7:4], i + 2); end
      tests++; if (bus.data_frame !== m_frame) begin fails++; $display("FAIL ovf_sb%0d got %h want %h", i, bus.data_frame, m_frame); end
    end
    step(1'b0, 10'd0, 9'd0, 5'd0, 1'b0, 1'b1);
    tests++; if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin fails++; $display("FAIL clear got ovf=%b drop=%0d want 0/0", bus.overflow, bus.drop_cnt); end
    for (int i = 0; i < 4; i++) push_rand(1'b0);
    step(1'b1, 10'h3FF, 9'h1FF, 5'h1F, 1'b0, 1'b1);
    tests++; if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1) begin fails++; $display("FAIL clear_vs_ovf got ovf=%b drop=%0d want 1/1", bus.overflow, bus.drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      req();
      tests++; if (bus.data_frame !== m_frame) begin fails++; $display("FAIL drain_sb%0d got %h want %h", i, bus.data_frame, m_frame); end
    end
  endtask

  task automatic test_wrap();
    assert_reset();
    release_reset();
    for (int i = 0; i < 17; i++) begin
      push_rand(1'b0);
      req();
      tests++; if (bus.data_frame[7:4] !== 4'(i % 16)) begin fails++; $display("FAIL wrap_seq%0d got %0d want %0d", i, bus.data_frame[7:4], i % 16); end
      tests++; if (bus.data_frame !== m_frame || bus.frame_fresh !== 1'b1) begin fails++; $display("FAIL wrap_sb%0d got %h/%b want %h/1", i, bus.data_frame, bus.frame_fresh, m_frame); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    for (int i = 0; i < 4; i++) push_rand(1'b0);
    push_rand(1'b1);
    tests++; if (bus.fifo_count !== 3'd4) begin fails++; $display("FAIL simul_full_count got %0d want 4", bus.fifo_count); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL simul_full_ovf got %b want 0", bus.overflow); end
    tests++; if (bus.data_frame !== m_frame || bus.frame_fresh !== 1'b1) begin fails++; $display("FAIL simul_full_sb got %h want %h", bus.data_frame, m_frame); end
    for (int i = 0; i < 4; i++) begin
      req();
      tests++; if (bus.data_frame !== m_frame) begin fails++; $display("FAIL simul_drain%0d got %h want %h", i, bus.data_frame, m_frame); end
    end
    held = m_frame;
    push_rand(1'b1);
    tests++; if (bus.fifo_count !== 3'd1) begin fails++; $display("FAIL simul_empty_count got %0d want 1", bus.fifo_count); end
    tests++; if (bus.frame_fresh !== 1'b0) begin fails++; $display("FAIL simul_empty_fresh got %b want 0", bus.frame_fresh); end
    tests++; if (bus.data_frame !== held) begin fails++; $display("FAIL simul_empty_hold got %h want %h", bus.data_frame, held); end
    req();
    tests++; if (bus.data_frame !== m_frame || bus.fifo_count !== 3'd0) begin fails++; $display("FAIL simul_empty_pop got %h want %h", bus.data_frame, m_frame); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) push_rand(1'b0);
    req();
    tests++; if (bus.fifo_count !== 3'd3 || bus.overflow !== 1'b1) begin fails++; $display("FAIL mid_pre got cnt=%0d ovf=%b want 3/1", bus.fifo_count, bus.overflow); end
    assert_reset();
    tests++; if (bus.data_frame !== 32'd0 || bus.frame_fresh !== 1'b0 || bus.fifo_count !== 3'd0 ||
                 bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      fails++; $display("FAIL mid_reset got %h/%b/%0d/%b/%0d want all 0", bus.data_frame, bus.frame_fresh,
                        bus.fifo_count, bus.overflow, bus.drop_cnt);
    end
    release_reset();
    req();
    tests++; if (bus.frame_fresh !== 1'b0 || bus.data_frame !== 32'd0) begin fails++; $display("FAIL mid_flushed got %h/%b want 0/0", bus.data_frame, bus.frame_fresh); end
    push_rand(1'b0);
    req();
    tests++; if (bus.data_frame[7:4] !== 4'd0) begin fails++; $display("FAIL mid_seq0 got %0d want 0", bus.data_frame[7:4]); end
    tests++; if (bus.data_frame !== m_frame) begin fails++; $display("FAIL mid_sb got %h want %h", bus.data_frame, m_frame); end
  endtask

  initial begin
    bus.sample_valid = 1'b0; bus.xdata = '0; bus.ydata = '0; bus.etc = '0;
    bus.frame_req = 1'b0; bus.clear_ovf = 1'b0;
    test_reset();
    test_single();
    test_empty_req();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
